tpg_multi: RTL and testbench

- Parametrised successor of the single-pattern test pattern generator: a programmable raster timing generator (hs/vs/de) plus a multi-channel pixel source with four selectable patterns.
- Sits at the head of the video pipeline and drives the downstream sink directly; there is no backpressure.
- Timing and mode are sampled once per frame so that a frame is never torn.
- Adds an enable input, a frame counter and a start-of-frame marker.

---
 rtl/tpg_pkg.sv | 18 +
 rtl/tpg_timing.sv | 127 ++++++++++++
 rtl/tpg_multi.sv | 102 ++++++++++
 tb/tb_tpg_multi.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tpg_pkg.sv
// Shared encodings for the multi-channel test pattern generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tpg_pkg;

  typedef enum logic [1:0] {
    MODE_RAMP  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHK   = 2'd2,
    MODE_SOLID = 2'd3
  } mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tpg_timing.sv
// Raster timing: x/y counters, per-frame timing shadows, hs/vs/de/sof, frame counter.
// Latency: hs/vs/de/sof registered one clock after the (x,y) position they describe.
// Backpressure: none; counters advance every clock while running.
module tpg_timing #(
  parameter int H_BITS  = 12,
  parameter int V_BITS  = 12,
  parameter int FC_BITS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [H_BITS-1:0]  h_total,
  input  logic [H_BITS-1:0]  hs_start,
  input  logic [H_BITS-1:0]  hs_end,
  input  logic [H_BITS-1:0]  hact_start,
  input  logic [H_BITS-1:0]  hact_end,
  input  logic [V_BITS-1:0]  v_total,
  input  logic [V_BITS-1:0]  vs_start,
  input  logic [V_BITS-1:0]  vs_end,
  input  logic [V_BITS-1:0]  vact_start,
  input  logic [V_BITS-1:0]  vact_end,
  output logic [H_BITS-1:0]  x,
  output logic [V_BITS-1:0]  y,
  output logic [H_BITS-1:0]  hactStartSh,
  output logic [V_BITS-1:0]  vactStartSh,
  output logic               deNow,
  output logic               frameStart,
  output logic               loadShadow,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic               sof,
  output logic [FC_BITS-1:0] frame_cnt
);
  import tpg_pkg::*;

  localparam logic [H_BITS-1:0]  H_ONE  = 1;
  localparam logic [V_BITS-1:0]  V_ONE  = 1;
  localparam logic [FC_BITS-1:0] FC_ONE = 1;

  state_t            state;
  logic [H_BITS-1:0] hTotalSh, hsStartSh, hsEndSh, hactEndSh;
  logic [V_BITS-1:0] vTotalSh, vsStartSh, vsEndSh, vactEndSh;
  logic              running, lineEnd, frameEnd, hsNow, vsNow;

  // Position decode; ranges are half-open so start >= end never asserts,
  // and x/y never exceed total-1 so oversized ends clip naturally.
  assign running    = (state == RUN);
  assign lineEnd    = running && (x == hTotalSh - H_ONE);
  assign frameEnd   = lineEnd && (y == vTotalSh - V_ONE);
  assign loadShadow = en && ((state == IDLE) || frameEnd);
  assign frameStart = running && (x == '0) && (y == '0);
  assign hsNow      = running && (x >= hsStartSh) && (x < hsEndSh);
  assign vsNow      = running && (y >= vsStartSh) && (y < vsEndSh);
  assign deNow      = running && (x >= hactStartSh) && (x < hactEndSh)
                              && (y >= vactStartSh) && (y < vactEndSh);

  // Run/idle FSM, raster counters, timing shadows and completed-frame count
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      frame_cnt   <= '0;
      hTotalSh    <= '0;
      hsStartSh   <= '0;
      hsEndSh     <= '0;
      hactStartSh <= '0;
      hactEndSh   <= '0;
      vTotalSh    <= '0;
      vsStartSh   <= '0;
      vsEndSh     <= '0;
      vactStartSh <= '0;
      vactEndSh   <= '0;
    end else begin
      if (loadShadow) begin
        hTotalSh    <= h_total;
        hsStartSh   <= hs_start;
        hsEndSh     <= hs_end;
        hactStartSh <= hact_start;
        hactEndSh   <= hact_end;
        vTotalSh    <= v_total;
        vsStartSh   <= vs_start;
        vsEndSh     <= vs_end;
        vactStartSh <= vact_start;
        vactEndSh   <= vact_end;
      end
      case (state)
        IDLE: begin
          x <= '0;
          y <= '0;
          if (en) state <= RUN;
        end
        RUN: begin
          if (frameEnd) begin
            x         <= '0;
            y         <= '0;
            frame_cnt <= frame_cnt + FC_ONE;
            if (!en) state <= IDLE;
          end else if (lineEnd) begin
            x <= '0;
            y <= y + V_ONE;
          end else begin
            x <= x + H_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register the raster flags one clock behind the counters
  always_ff @(posedge clk) begin
    if (rst) begin
      hs  <= 1'b0;
      vs  <= 1'b0;
      de  <= 1'b0;
      sof <= 1'b0;
    end else begin
      hs  <= hsNow;
      vs  <= vsNow;
      de  <= deNow;
      sof <= frameStart;
    end
  end

endmodule

// File: rtl/tpg_multi.sv
// Programmable raster generator with an NCH-channel four-pattern pixel source.
// Latency: every output registered, one clock after the (x,y) counter position.
// Backpressure: none; the downstream sink must take a pixel every clock.
module tpg_multi #(
  parameter int PW        = 8,
  parameter int NCH       = 3,
  parameter int H_BITS    = 12,
  parameter int V_BITS    = 12,
  parameter int FC_BITS   = 16,
  parameter int BAR_SHIFT = 5,
  parameter int CHK_SHIFT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [NCH*PW-1:0]   solid_pix,
  input  logic [H_BITS-1:0]   h_total,
  input  logic [H_BITS-1:0]   hs_start,
  input  logic [H_BITS-1:0]   hs_end,
  input  logic [H_BITS-1:0]   hact_start,
  input  logic [H_BITS-1:0]   hact_end,
  input  logic [V_BITS-1:0]   v_total,
  input  logic [V_BITS-1:0]   vs_start,
  input  logic [V_BITS-1:0]   vs_end,
  input  logic [V_BITS-1:0]   vact_start,
  input  logic [V_BITS-1:0]   vact_end,
  output logic                hs,
  output logic                vs,
  output logic                de,
  output logic                sof,
  output logic [NCH*PW-1:0]   pix,
  output logic [FC_BITS-1:0]  frame_cnt
);
  import tpg_pkg::*;

  localparam logic [PW-1:0] PW_ONE = 1;

  logic [H_BITS-1:0] x, hactSh;
  logic [V_BITS-1:0] y, vactSh;
  logic              deNow, frameStart, loadShadow;
  mode_t             modeSh;
  logic [NCH*PW-1:0] solidSh, rampPix, barPix, patPix;
  logic [PW-1:0]     rampCnt, rampIdx;
  logic [2:0]        bar;
  logic              chkX, chkY;

  tpg_timing #(.H_BITS(H_BITS), .V_BITS(V_BITS), .FC_BITS(FC_BITS)) uTiming (
    .clk(clk), .rst(rst), .en(en),
    .h_total(h_total), .hs_start(hs_start), .hs_end(hs_end),
    .hact_start(hact_start), .hact_end(hact_end),
    .v_total(v_total), .vs_start(vs_start), .vs_end(vs_end),
    .vact_start(vact_start), .vact_end(vact_end),
    .x(x), .y(y), .hactStartSh(hactSh), .vactStartSh(vactSh),
    .deNow(deNow), .frameStart(frameStart), .loadShadow(loadShadow),
    .hs(hs), .vs(vs), .de(de), .sof(sof), .frame_cnt(frame_cnt)
  );

  // Active-area coordinate bits; only meaningful while deNow is high
  assign bar  = 3'((x - hactSh) >> BAR_SHIFT);
  assign chkX = 1'((x - hactSh) >> CHK_SHIFT);
  assign chkY = 1'((y - vactSh) >> CHK_SHIFT);

  // Ramp index restarts at every frame start, otherwise continues from the last de pixel
  assign rampIdx = frameStart ? '0 : rampCnt;

  for (genvar c = 0; c < NCH; c++) begin : gCh
    localparam int BI = c % 3;
    assign rampPix[c*PW +: PW] = rampIdx;
    assign barPix[c*PW +: PW]  = {PW{bar[BI]}};
  end

  // Pattern select from the frame's sampled mode
  always_comb begin
    patPix = '0;
    case (modeSh)
      MODE_RAMP:  patPix = rampPix;
      MODE_BARS:  patPix = barPix;
      MODE_CHK:   patPix = (chkX ^ chkY) ? '1 : '0;
      MODE_SOLID: patPix = solidSh;
      default:    patPix = '0;
    endcase
  end

  // Mode/solid shadows, pixel output register and ramp counter
  always_ff @(posedge clk) begin
    if (rst) begin
      modeSh  <= MODE_RAMP;
      solidSh <= '0;
      pix     <= '0;
      rampCnt <= '0;
    end else begin
      if (loadShadow) begin
        modeSh  <= mode_t'(mode);
        solidSh <= solid_pix;
      end
      pix     <= deNow ? patPix : '0;
      rampCnt <= deNow ? rampIdx + PW_ONE : rampIdx;
    end
  end

endmodule

// File: tb/tb_tpg_multi.sv
module tb_tpg_multi;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en;
  logic [1:0]  mode;
  logic [23:0] solid_pix;
  logic [11:0] h_total, hs_start, hs_end, hact_start, hact_end;
  logic [11:0] v_total, vs_start, vs_end, vact_start, vact_end;
  logic        hs, vs, de, sof;
  logic [23:0] pix;
  logic [15:0] frame_cnt;

  tpg_multi #(.BAR_SHIFT(1), .CHK_SHIFT(1)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_pix(solid_pix),
    .h_total(h_total), .hs_start(hs_start), .hs_end(hs_end),
    .hact_start(hact_start), .hact_end(hact_end),
    .v_total(v_total), .vs_start(vs_start), .vs_end(vs_end),
    .vact_start(vact_start), .vact_end(vact_end),
    .hs(hs), .vs(vs), .de(de), .sof(sof), .pix(pix), .frame_cnt(frame_cnt)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [23:0] solid;
    logic [11:0] ht, hss, hse, has, hae, vt, vss, vse, vas, vae;
    int          len, nHs, nVs, nDe;
    logic [23:0] pixFirst, pixLast;
  } vec_t;

  vec_t        vecs[5];
  logic [23:0] barExp[8];
  logic [23:0] pixLog[256];
  int          fLen, fHs, fVs, fDe;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyVec(input vec_t v);
    mode = v.mode; solid_pix = v.solid;
    h_total = v.ht; hs_start = v.hss; hs_end = v.hse; hact_start = v.has; hact_end = v.hae;
    v_total = v.vt; vs_start = v.vss; vs_end = v.vse; vact_start = v.vas; vact_end = v.vae;
  endtask

  task automatic waitSof(input string name);
    int n = 0;
    tick();
    while (sof !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    if (sof !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: sof=%b after 400 cycles, expected 1", name, sof);
    end
  endtask

  // Starts on a cycle showing sof, counts until the next sof; optionally
  // switches mode to checker and h_total to 12 at cycle chgAt of the frame.
  task automatic measure(input string name, input int chgAt);
    int n = 0;
    fLen = 0; fHs = 0; fVs = 0; fDe = 0;
    do begin
      fLen++;
      if (hs) fHs++;
      if (vs) fVs++;
      if (de) begin
        if (fDe < 256) pixLog[fDe] = pix;
        fDe++;
      end
      if (n == chgAt) begin
        mode = 2'd2;
        h_total = 12'd12;
      end
      tick();
      n++;
    end while (sof !== 1'b1 && n < 400);
    if (sof !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: frame end sof=%b after 400 cycles, expected 1", name, sof);
    end
  endtask

  initial begin
    int          bad;
    logic [15:0] fc;
    logic [7:0]  b;

    //          mode   solid       ht  hss hse has hae vt vss vse vas vae  len hs vs de  first      last
    vecs[0] = '{2'd0, 24'h000000, 10, 1,  3,  4,  9,  6, 0,  1,  2,  5,   60, 12, 10, 15, 24'h000000, 24'h0E0E0E};
    vecs[1] = '{2'd0, 24'h000000, 10, 3,  3,  4,  9,  6, 0,  1,  2,  9,   60, 0,  10, 20, 24'h000000, 24'h131313};
    vecs[2] = '{2'd3, 24'hABCDEF, 10, 8,  15, 4,  9,  6, 4,  2,  2,  5,   60, 12, 0,  15, 24'hABCDEF, 24'hABCDEF};
    vecs[3] = '{2'd2, 24'h000000, 8,  0,  8,  0,  8,  6, 2,  4,  0,  6,   48, 48, 16, 48, 24'h000000, 24'hFFFFFF};
    vecs[4] = '{2'd1, 24'h000000, 20, 0,  1,  2,  18, 3, 0,  1,  0,  1,   60, 3,  20, 16, 24'h000000, 24'hFFFFFF};
    barExp = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
               24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};

    // Reset and idle state
    rst = 1'b1; en = 1'b0;
    applyVec(vecs[0]);
    repeat (3) tick();
    check("reset_flags", {hs, vs, de, sof}, 4'b0);
    check("reset_pix_fc", {pix, frame_cnt}, 40'h0);
    rst = 1'b0;
    repeat (3) tick();
    check("idle_quiet", {hs, vs, de, sof, pix, frame_cnt}, 44'h0);

    // Enable from idle: sof two clocks later, first frame counted
    en = 1'b1;
    tick();
    check("en_sof_1clk", sof, 1'b0);
    tick();
    check("en_sof_2clk", sof, 1'b1);
    check("first_fc0", frame_cnt, 16'd0);
    measure("first", -1);
    check("first_len", fLen, 60);
    check("first_fc1", frame_cnt, 16'd1);

    // Table of raster/pattern configurations
    for (int i = 0; i < 5; i++) begin
      applyVec(vecs[i]);
      waitSof($sformatf("v%0d_start", i));
      fc = frame_cnt;
      measure($sformatf("v%0d", i), -1);
      check($sformatf("v%0d_len", i), fLen, vecs[i].len);
      check($sformatf("v%0d_hs", i), fHs, vecs[i].nHs);
      check($sformatf("v%0d_vs", i), fVs, vecs[i].nVs);
      check($sformatf("v%0d_de", i), fDe, vecs[i].nDe);
      check($sformatf("v%0d_pix_first", i), pixLog[0], vecs[i].pixFirst);
      check($sformatf("v%0d_pix_last", i), pixLog[vecs[i].nDe-1], vecs[i].pixLast);
      check($sformatf("v%0d_fc", i), frame_cnt, 16'(fc + 16'd1));
      if (vecs[i].mode == 2'd0) begin
        bad = 0;
        for (int k = 0; k < fDe && k < 256; k++) begin
          b = k[7:0];
          if (pixLog[k] !== {b, b, b}) bad++;
        end
        check($sformatf("v%0d_ramp_bad", i), bad, 0);
      end
      if (vecs[i].mode == 2'd1) begin
        bad = 0;
        for (int k = 0; k < 16; k++)
          if (pixLog[k] !== barExp[k >> 1]) bad++;
        check($sformatf("v%0d_bars_bad", i), bad, 0);
      end
    end

    // Mid-frame mode/h_total change takes effect only on the next frame
    applyVec(vecs[0]);
    mode = 2'd3; solid_pix = 24'h123456;
    waitSof("samp_start");
    measure("samp_cur", 20);
    check("samp_cur_len", fLen, 60);
    bad = 0;
    for (int k = 0; k < fDe && k < 256; k++)
      if (pixLog[k] !== 24'h123456) bad++;
    check("samp_cur_solid_bad", bad, 0);
    check("samp_cur_de", fDe, 15);
    measure("samp_next", -1);
    check("samp_next_len", fLen, 72);
    check("samp_next_de", fDe, 15);
    check("samp_next_pix1", pixLog[1], 24'h000000);
    check("samp_next_pix2", pixLog[2], 24'hFFFFFF);
    check("samp_next_pix14", pixLog[14], 24'hFFFFFF);

    // Drop en mid-frame: frame completes, then quiet and frame_cnt held
    applyVec(vecs[0]);
    waitSof("endrop_start");
    fc = frame_cnt;
    repeat (2) tick();
    en = 1'b0;
    repeat (58) tick();
    check("endrop_fc", frame_cnt, 16'(fc + 16'd1));
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      if ({hs, vs, de, sof, pix} !== 28'h0 || frame_cnt !== 16'(fc + 16'd1)) bad++;
      tick();
    end
    check("endrop_quiet_bad", bad, 0);

    // Raise en again
    en = 1'b1;
    tick();
    check("reen_sof_1clk", sof, 1'b0);
    tick();
    check("reen_sof_2clk", sof, 1'b1);
    check("reen_fc", frame_cnt, 16'(fc + 16'd1));

    // Reset mid-frame with the counters at x=5, y=3
    repeat (34) tick();
    check("midrst_de_before", de, 1'b1);
    check("midrst_pix_before", pix, 24'h050505);
    rst = 1'b1;
    tick();
    check("midrst_zero", {hs, vs, de, sof, pix, frame_cnt}, 44'h0);
    rst = 1'b0;
    tick();
    check("midrst_sof_1clk", sof, 1'b0);
    tick();
    check("midrst_sof_2clk", sof, 1'b1);
    check("midrst_fc", frame_cnt, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
